// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and helpers for the button event arbiter.
//   HOLD_W  - width of the per-button long-press hold counter
//   id_w    - width of a button index for a given button count
//   rr_next - next index in round-robin order, wrapping at n-1
package btn_pkg;
    localparam int HOLD_W = 8;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/btn_evt_arb_if.sv
// btn_evt_arb_if: event valid/ready channel from the arbiter to its consumer.
//   evt_valid - an event is presented (master -> slave)
//   evt_ready - consumer accepts the event (slave -> master)
//   evt_id    - index of the button that produced the event
//   evt_long  - 1 = long-press event, 0 = press event
interface btn_evt_arb_if #(parameter int ID_W = 3);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_long;

    modport master(output evt_valid, output evt_id, output evt_long, input evt_ready);
    modport slave(input evt_valid, input evt_id, input evt_long, output evt_ready);
endinterface

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin pick starting one past last_grant.
//   req        - request vector
//   last_grant - index granted most recently
//   grant_vld  - at least one request present
//   grant_idx  - winning index
module rr_arb import btn_pkg::*; #(
    parameter int N    = 8,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic            grant_vld,
    output logic [ID_W-1:0] grant_idx
);
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = last_grant;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'(rr_next(int'(idx), N));
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end
endmodule

// File: rtl/btn_evt_arb.sv
// btn_evt_arb: debounce-by-sampling button block that turns presses into arbitrated events.
//   clk, rst_n - clock, synchronous active-low reset
//   btn_in     - raw asynchronous button levels
//   btn_lvl    - sampled levels, 1 = pressed
//   evt_ovf    - sticky flag: an event was dropped
//   evt        - event channel (master side of btn_evt_arb_if)
// Optional feature: define LONG_PRESS_EN to add per-button long-press events.
module btn_evt_arb import btn_pkg::*; #(
    parameter int   BT_WIDTH   = 8,
    parameter int   TICK_W     = 18,
    parameter logic PRESS_LVL  = 1'b0,
    parameter int   LONG_TICKS = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BT_WIDTH-1:0] btn_in,
    output logic [BT_WIDTH-1:0] btn_lvl,
    output logic                evt_ovf,
    btn_evt_arb_if.master       evt
);
    localparam int ID_W = id_w(BT_WIDTH);

    logic [TICK_W-1:0]   tick_q;
    logic [BT_WIDTH-1:0] sync1_q, sync2_q, lvl_q, pend_s_q, pend_s_d, pend_l_q;
    logic [BT_WIDTH-1:0] norm, set_s, clr_s, gmask, drop_s, drop_l;
    logic                sample, load, grant_vld, valid_q, valid_d, long_q, ovf_q, ovf_d;
    logic [ID_W-1:0]     grant_idx, id_q, last_q;

    // xnor maps the pressed level to 1 whatever its polarity
    assign norm   = sync2_q ~^ {BT_WIDTH{PRESS_LVL}};
    assign sample = &tick_q;
    assign set_s  = sample ? (norm & ~lvl_q) : '0;

    rr_arb #(.N(BT_WIDTH), .ID_W(ID_W)) u_rr_arb (
        .req        (pend_s_q | pend_l_q),
        .last_grant (last_q),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    assign load  = grant_vld && (!valid_q || evt.evt_ready);
    assign gmask = BT_WIDTH'(1) << grant_idx;
    // a short press on the granted index is served before its long press
    assign clr_s = (load && pend_s_q[grant_idx]) ? gmask : '0;
    // a set landing while the same bit is being granted is not a drop
    assign drop_s   = set_s & pend_s_q & ~clr_s;
    assign pend_s_d = (pend_s_q & ~clr_s) | set_s;
    assign ovf_d    = ovf_q | (|(drop_s | drop_l));
    assign valid_d  = load | (valid_q & ~evt.evt_ready);

`ifdef LONG_PRESS_EN
    logic [HOLD_W-1:0]   hold_q [BT_WIDTH];
    logic [BT_WIDTH-1:0] set_l, clr_l;

    // the hold counter saturates at LONG_TICKS, so this matches once per press
    always_comb begin
        set_l = '0;
        for (int i = 0; i < BT_WIDTH; i++)
            set_l[i] = sample && norm[i] && (hold_q[i] == HOLD_W'(LONG_TICKS - 1));
    end

    assign clr_l  = (load && !pend_s_q[grant_idx]) ? gmask : '0;
    assign drop_l = set_l & pend_l_q & ~clr_l;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_l_q <= '0;
            for (int i = 0; i < BT_WIDTH; i++) hold_q[i] <= '0;
        end else begin
            pend_l_q <= (pend_l_q & ~clr_l) | set_l;
            if (sample)
                for (int i = 0; i < BT_WIDTH; i++)
                    hold_q[i] <= !norm[i] ? '0 :
                                 (hold_q[i] == HOLD_W'(LONG_TICKS)) ? hold_q[i] : hold_q[i] + 1'b1;
        end
    end
`else
    assign pend_l_q = '0;
    assign drop_l   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            pend_s_q <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            long_q   <= 1'b0;
            ovf_q    <= 1'b0;
            last_q   <= ID_W'(BT_WIDTH - 1);
        end else begin
            tick_q   <= tick_q + 1'b1;
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            pend_s_q <= pend_s_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            if (sample) lvl_q <= norm;
            if (load) begin
                id_q   <= grant_idx;
                long_q <= !pend_s_q[grant_idx];
                last_q <= grant_idx;
            end
        end
    end

    assign btn_lvl       = lvl_q;
    assign evt_ovf       = ovf_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign evt.evt_long  = long_q;
endmodule

// File: tb/tb_btn_evt_arb.sv
// tb_btn_evt_arb: self-checking bench for btn_evt_arb (vector table + scoreboard + corner sequences).
module tb_btn_evt_arb;
`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]      press;
        logic [3:0]      lvl;
        logic [1:0]      n;
        logic [2:0][1:0] ids;
        logic [2:0]      lgs;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic       lg;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = 4'hF;
    logic [3:0] btn_lvl;
    logic       ovf;
    int         tests = 0, fails = 0, hs_cnt = 0, cyc = 0;
    ev_t        sb[$];
    vec_t       vecs[14];
    logic       stall_q = 1'b0, stall_lg;
    logic [1:0] stall_id;

    btn_evt_arb_if #(.ID_W(2)) ev();

    btn_evt_arb #(.BT_WIDTH(4), .TICK_W(4), .PRESS_LVL(1'b0), .LONG_TICKS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_in),
        .btn_lvl (btn_lvl),
        .evt_ovf (ovf),
        .evt     (ev)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic lg);
        sb.push_back('{id: id, lg: lg});
    endtask

    task automatic next_sample();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while ((cyc % 16 != 0) && k < 40);
        if (k >= 40) check("sample_timeout", k, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) stall_q = 1'b0;
        else begin
            if (stall_q)
                check("stall_hold", {ev.evt_valid, ev.evt_id, ev.evt_long}, {1'b1, stall_id, stall_lg});
            if (ev.evt_valid && ev.evt_ready) begin
                ev_t e;
                hs_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_evt: got id %0d long %0b, expected none", ev.evt_id, ev.evt_long);
                end else begin
                    e = sb.pop_front();
                    check("evt_id", ev.evt_id, e.id);
                    check("evt_long", ev.evt_long, e.lg);
                end
            end
            stall_q  = ev.evt_valid && !ev.evt_ready;
            stall_id = ev.evt_id;
            stall_lg = ev.evt_long;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0;
        vecs[0]  = '{press: 4'b1011, lvl: 4'b1011, n: 2'd3, ids: {2'd3, 2'd1, 2'd0}, lgs: 3'b000};
        vecs[1]  = '{press: 4'b0000, lvl: 4'b0000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[2]  = '{press: 4'b1011, lvl: 4'b1011, n: 2'd3, ids: {2'd3, 2'd1, 2'd0}, lgs: 3'b000};
        vecs[3]  = '{press: 4'b0000, lvl: 4'b0000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[4]  = '{press: 4'b0100, lvl: 4'b0100, n: 2'd1, ids: {2'd0, 2'd0, 2'd2}, lgs: 3'b000};
        vecs[5]  = '{press: 4'b0011, lvl: 4'b0011, n: 2'd2, ids: {2'd0, 2'd1, 2'd0}, lgs: 3'b000};
        vecs[6]  = '{press: 4'b0011, lvl: 4'b0011, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[7]  = '{press: 4'b0000, lvl: 4'b0000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[8]  = '{press: 4'b1000, lvl: 4'b1000, n: 2'd1, ids: {2'd0, 2'd0, 2'd3}, lgs: 3'b000};
        vecs[9]  = '{press: 4'b1000, lvl: 4'b1000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[10] = '{press: 4'b1000, lvl: 4'b1000, n: LP ? 2'd1 : 2'd0, ids: {2'd0, 2'd0, 2'd3}, lgs: 3'b001};
        vecs[11] = '{press: 4'b1000, lvl: 4'b1000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[12] = '{press: 4'b1000, lvl: 4'b1000, n: 2'd0, ids: '0, lgs: 3'b000};
        vecs[13] = '{press: 4'b0000, lvl: 4'b0000, n: 2'd0, ids: '0, lgs: 3'b000};

        ev.evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_lvl", btn_lvl, 4'b0000);
        check("rst_valid", ev.evt_valid, 1'b0);
        check("rst_id", ev.evt_id, 2'd0);
        check("rst_long", ev.evt_long, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            btn_in = ~vecs[r].press;
            next_sample();
            check("lvl", btn_lvl, vecs[r].lvl);
            for (int j = 0; j < int'(vecs[r].n); j++) push(vecs[r].ids[j], vecs[r].lgs[j]);
            if (vecs[r].n != 0) begin
                check("lat_at_sample", ev.evt_valid, 1'b0);
                @(posedge clk);
                #1;
                check("lat_plus2", ev.evt_valid, 1'b1);
                if (vecs[r].n == 1) begin
                    @(posedge clk);
                    #1;
                    check("one_cycle", ev.evt_valid, 1'b0);
                end
            end
            repeat (6) @(posedge clk);
            #1;
            check("drain", sb.size(), 0);
            check("idle", ev.evt_valid, 1'b0);
        end
        check("no_ovf", ovf, 1'b0);

        // backpressure: id 1 held while stalled, id 2 right after ready rises
        ev.evt_ready = 1'b0;
        btn_in = ~4'b0110;
        next_sample();
        check("bp_lvl", btn_lvl, 4'b0110);
        push(2'd1, 1'b0);
        push(2'd2, 1'b0);
        btn_in = 4'hF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {ev.evt_valid, ev.evt_id}, {1'b1, 2'd1});
            @(posedge clk);
            #1;
        end
        ev.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_next", {ev.evt_valid, ev.evt_id}, {1'b1, 2'd2});
        @(posedge clk);
        #1;
        check("bp_done", ev.evt_valid, 1'b0);
        check("bp_drain", sb.size(), 0);

        // overflow: third press of button 0 lands while pend_s[0] is still set
        ev.evt_ready = 1'b0;
        push(2'd0, 1'b0);
        push(2'd0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            btn_in = (s % 2 == 0) ? 4'b1110 : 4'b1111;
            next_sample();
            if (s == 3) check("ovf_before", ovf, 1'b0);
        end
        check("ovf_set", ovf, 1'b1);
        btn_in = 4'hF;
        next_sample();
        ev.evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ovf_drain", sb.size(), 0);
        check("ovf_idle", ev.evt_valid, 1'b0);
        check("ovf_sticky", ovf, 1'b1);

        // reset while an event is presented and two more are pending
        ev.evt_ready = 1'b0;
        btn_in = ~4'b1011;
        next_sample();
        @(posedge clk);
        #1;
        check("pre_rst_valid", ev.evt_valid, 1'b1);
        rst_n = 1'b0;
        btn_in = 4'hF;
        @(posedge clk);
        #1;
        check("mid_rst_outs", {ev.evt_valid, ev.evt_id, ev.evt_long, ovf, btn_lvl}, 9'd0);
        rst_n = 1'b1;
        sb.delete();
        ev.evt_ready = 1'b1;
        h0 = hs_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("no_evt_after_rst", hs_cnt, h0);
        btn_in = ~4'b0100;
        next_sample();
        push(2'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_evt", hs_cnt, h0 + 1);
        check("post_rst_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
